// File: rtl/reg_select_sequencer_if.sv
// Purpose: request/response bundle between a controller and the select sequencer.
// Latency: n/a (signal bundle only).
// Backpressure: i_hold stalls an active sweep; there is no other flow control.
interface reg_select_sequencer_if #(
  parameter int IDX_W = 4
);
  localparam int OUT_W = 1 << IDX_W;

  // Requests towards the sequencer
  logic             i_en;
  logic [IDX_W-1:0] i_idx;
  logic             i_sweep_start;
  logic [IDX_W-1:0] i_sweep_first;
  logic [IDX_W-1:0] i_sweep_last;
  logic             i_hold;

  // Registered responses from the sequencer
  logic [OUT_W-1:0] o_sel;
  logic             o_sel_valid;
  logic [IDX_W-1:0] o_cur_idx;
  logic             o_busy;
  logic             o_done;

  modport master (
    output i_en, i_idx, i_sweep_start, i_sweep_first, i_sweep_last, i_hold,
    input  o_sel, o_sel_valid, o_cur_idx, o_busy, o_done
  );

  modport slave (
    input  i_en, i_idx, i_sweep_start, i_sweep_first, i_sweep_last, i_hold,
    output o_sel, o_sel_valid, o_cur_idx, o_busy, o_done
  );
endinterface

// File: rtl/reg_select_sequencer.sv
// Purpose: one-hot select driver; direct decode of an index or a wrapping index sweep.
// Latency: one cycle from a sampled request to the registered select.
// Backpressure: i_hold freezes a sweep (select forced to zero) and resumes at the next index.
module reg_select_sequencer #(
  parameter int IDX_W = 4
) (
  input  logic                   i_clock,
  input  logic                   i_clear,
  reg_select_sequencer_if.slave  bus
);
  localparam int OUT_W = 1 << IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_last;
  logic [IDX_W-1:0] r_cur_idx;
  logic [OUT_W-1:0] r_sel;
  logic             r_sel_valid;
  logic             r_busy;
  logic             r_done;

  // Next sweep index; natural IDX_W overflow gives the OUT_W-1 -> 0 wrap.
  logic [IDX_W-1:0] w_next_idx;
  assign w_next_idx = r_cur_idx + IDX_W'(1);

  function automatic logic [OUT_W-1:0] f_onehot(input logic [IDX_W-1:0] i_k);
    logic [OUT_W-1:0] v;
    v      = '0;
    v[i_k] = 1'b1;
    return v;
  endfunction

  // Single registered FSM: every output is a flop, so no input reaches an output combinationally.
  always_ff @(posedge i_clock or posedge i_clear) begin
    if (i_clear) begin
      r_state     <= ST_IDLE;
      r_last      <= '0;
      r_cur_idx   <= '0;
      r_sel       <= '0;
      r_sel_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.i_sweep_start) begin
            // Sweep request outranks a simultaneous direct decode.
            r_state     <= ST_SWEEP;
            r_last      <= bus.i_sweep_last;
            r_cur_idx   <= bus.i_sweep_first;
            r_sel       <= f_onehot(bus.i_sweep_first);
            r_sel_valid <= 1'b1;
            r_busy      <= 1'b1;
          end else if (bus.i_en) begin
            r_cur_idx   <= bus.i_idx;
            r_sel       <= f_onehot(bus.i_idx);
            r_sel_valid <= 1'b1;
          end else begin
            r_cur_idx   <= '0;
            r_sel       <= '0;
            r_sel_valid <= 1'b0;
          end
        end
        ST_SWEEP: begin
          if (bus.i_hold) begin
            // Stall: keep the index so the sweep resumes without skip or repeat.
            r_sel       <= '0;
            r_sel_valid <= 1'b0;
          end else if (r_cur_idx == r_last) begin
            r_state     <= ST_DONE;
            r_cur_idx   <= '0;
            r_sel       <= '0;
            r_sel_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
          end else begin
            r_cur_idx   <= w_next_idx;
            r_sel       <= f_onehot(w_next_idx);
            r_sel_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          // One-cycle completion pulse; requests seen here are dropped.
          r_state     <= ST_IDLE;
          r_cur_idx   <= '0;
          r_sel       <= '0;
          r_sel_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cur_idx   <= '0;
          r_sel       <= '0;
          r_sel_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_sel       = r_sel;
  assign bus.o_sel_valid = r_sel_valid;
  assign bus.o_cur_idx   = r_cur_idx;
  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;
endmodule

// File: tb/tb_reg_select_sequencer.sv
// Purpose: scoreboard bench for reg_select_sequencer with IDX_W=4.
// Latency: expects results one edge after each sampled request.
// Backpressure: exercises i_hold stalls mid-sweep.
module tb_reg_select_sequencer;
  logic clk;
  logic clr;

  reg_select_sequencer_if #(.IDX_W(4)) bus ();

  reg_select_sequencer #(.IDX_W(4)) dut (
    .i_clock (clk),
    .i_clear (clr),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] sel;
    logic [3:0]  cur;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int k, input logic busy, input logic done, input logic active);
    exp_t e;
    logic [15:0] one;
    one    = 16'h0001;
    e.sel  = active ? (one << k) : 16'h0000;
    e.cur  = active ? 4'(k) : 4'd0;
    e.busy = busy;
    e.done = done;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a select or a done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!clr) begin
      chk("onehot", 32'($countones(bus.o_sel) <= 1), 32'd1);
      chk("sel_valid_consistent", 32'(bus.o_sel_valid), 32'(bus.o_sel != 16'h0));
      if (bus.o_sel_valid || bus.o_done) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: sel=%h cur=%0d done=%0b, nothing expected at %0t",
                   bus.o_sel, bus.o_cur_idx, bus.o_done, $time);
        end else begin
          e = q.pop_front();
          chk("sb_sel",  32'(bus.o_sel),     32'(e.sel));
          chk("sb_cur",  32'(bus.o_cur_idx), 32'(e.cur));
          chk("sb_busy", 32'(bus.o_busy),    32'(e.busy));
          chk("sb_done", 32'(bus.o_done),    32'(e.done));
        end
      end
    end
  end

  task automatic chk_zero(input string name);
    chk({name, "_sel"},   32'(bus.o_sel),       32'd0);
    chk({name, "_valid"}, 32'(bus.o_sel_valid), 32'd0);
    chk({name, "_cur"},   32'(bus.o_cur_idx),   32'd0);
    chk({name, "_busy"},  32'(bus.o_busy),      32'd0);
    chk({name, "_done"},  32'(bus.o_done),      32'd0);
  endtask

  // Runs a sweep with en/idx noise throughout; optional hold after tick hold_after.
  task automatic do_sweep(input int first, input int last, input int hold_after,
                          input int hold_len, input int exp_busy, input string tag);
    int  k;
    int  busy_n;
    bit  seen_done;
    bit  held;
    k = first;
    for (int n = 0; n < 16; n++) begin
      q.push_back(mk(k, 1'b1, 1'b0, 1'b1));
      if (k == last) break;
      k = (k + 1) % 16;
    end
    q.push_back(mk(0, 1'b0, 1'b1, 1'b0));

    bus.i_sweep_first = 4'(first);
    bus.i_sweep_last  = 4'(last);
    bus.i_sweep_start = 1'b1;
    bus.i_en          = 1'b1;
    bus.i_idx         = 4'd12;
    busy_n    = 0;
    seen_done = 1'b0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      tick();
      held = bus.i_hold;
      if (cyc == 1) begin
        bus.i_sweep_start = 1'b0;
        bus.i_sweep_first = 4'd9;
        bus.i_sweep_last  = 4'd8;
      end
      bus.i_idx = 4'(cyc);
      if (bus.o_busy) busy_n++;
      if (held) begin
        chk({tag, "_hold_sel"},  32'(bus.o_sel),  32'd0);
        chk({tag, "_hold_busy"}, 32'(bus.o_busy), 32'd1);
      end
      if (bus.o_done) begin
        seen_done = 1'b1;
        break;
      end
      if (cyc == hold_after) bus.i_hold = 1'b1;
      if (cyc == hold_after + hold_len) bus.i_hold = 1'b0;
    end
    bus.i_hold = 1'b0;
    chk({tag, "_done_seen"},  32'(seen_done), 32'd1);
    chk({tag, "_busy_count"}, 32'(busy_n),    32'(exp_busy));
    // Edge in DONE with en still high: must be ignored and return to idle.
    tick();
    chk_zero({tag, "_after_done"});
    bus.i_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr               = 1'b1;
    bus.i_en          = 1'b0;
    bus.i_idx         = 4'd0;
    bus.i_sweep_start = 1'b0;
    bus.i_sweep_first = 4'd0;
    bus.i_sweep_last  = 4'd0;
    bus.i_hold        = 1'b0;
    #2;
    chk_zero("reset");
    @(negedge clk);
    #2;
    clr = 1'b0;
    tick();
    chk_zero("idle_after_reset");

    // Direct decode: idx 9 then release.
    bus.i_en  = 1'b1;
    bus.i_idx = 4'd9;
    q.push_back(exp_t'{sel: 16'h0200, cur: 4'd9, busy: 1'b0, done: 1'b0});
    tick();
    bus.i_en = 1'b0;
    tick();
    chk_zero("direct_release");

    // Direct decode back-to-back at both ends of the index range.
    bus.i_en  = 1'b1;
    bus.i_idx = 4'd0;
    q.push_back(exp_t'{sel: 16'h0001, cur: 4'd0, busy: 1'b0, done: 1'b0});
    tick();
    bus.i_idx = 4'd15;
    q.push_back(exp_t'{sel: 16'h8000, cur: 4'd15, busy: 1'b0, done: 1'b0});
    tick();
    bus.i_en = 1'b0;
    tick();
    chk_zero("direct_edges_release");

    // Sweeps (en=1 idx=12 issued alongside each start).
    do_sweep(2, 5, 0, 0, 4, "plain");
    do_sweep(14, 1, 0, 0, 4, "wrap");
    do_sweep(7, 7, 0, 0, 1, "single");
    do_sweep(0, 3, 2, 2, 6, "hold");

    // Asynchronous clear while the sweep 0..5 shows index 2.
    q.push_back(exp_t'{sel: 16'h0001, cur: 4'd0, busy: 1'b1, done: 1'b0});
    q.push_back(exp_t'{sel: 16'h0002, cur: 4'd1, busy: 1'b1, done: 1'b0});
    q.push_back(exp_t'{sel: 16'h0004, cur: 4'd2, busy: 1'b1, done: 1'b0});
    bus.i_sweep_first = 4'd0;
    bus.i_sweep_last  = 4'd5;
    bus.i_sweep_start = 1'b1;
    tick();
    bus.i_sweep_start = 1'b0;
    tick();
    tick();
    chk("pre_clear_cur", 32'(bus.o_cur_idx), 32'd2);
    #5;
    clr = 1'b1;
    #1;
    chk_zero("async_clear");
    #1;
    clr       = 1'b0;
    bus.i_en  = 1'b1;
    bus.i_idx = 4'd3;
    q.push_back(exp_t'{sel: 16'h0008, cur: 4'd3, busy: 1'b0, done: 1'b0});
    tick();
    bus.i_en = 1'b0;
    begin
      int done_n;
      done_n = 0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (bus.o_done) done_n++;
      end
      chk("no_done_after_abort", 32'(done_n), 32'd0);
    end
    chk_zero("final_idle");

    tick();
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_select_sequencer.md
REG_SELECT_SEQUENCER -- requirements
Module: reg_select_sequencer

Interface
REQ-001 Parameter IDX_W, default 4, SHALL set the index width; OUT_W = 2**IDX_W SHALL be derived, not overridable.
REQ-002 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 clear  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 en  input  1  direct-decode request, sampled in IDLE only.
REQ-005 idx  input  IDX_W  direct-decode index.
REQ-006 sweep_start  input  1  sweep request, sampled in IDLE only.
REQ-007 sweep_first  input  IDX_W  first sweep index, sampled with sweep_start.
REQ-008 sweep_last  input  IDX_W  last sweep index, sampled with sweep_start.
REQ-009 hold  input  1  sweep stall.
REQ-010 sel  output  OUT_W  registered one-hot select; bit k high means index k selected.
REQ-011 sel_valid  output  1  high exactly when sel is non-zero.
REQ-012 cur_idx  output  IDX_W  index currently encoded on sel; 0 when sel is 0.
REQ-013 busy  output  1  high in SWEEP.
REQ-014 done  output  1  one-cycle pulse in DONE.

Function
REQ-015 FSM states: IDLE, SWEEP, DONE; all outputs registered, no combinational input-to-output path.
REQ-016 IDLE, sweep_start=1: next cycle SWEEP, cur_idx=sweep_first, sel=onehot(sweep_first), latched last=sweep_last.
REQ-017 IDLE, sweep_start=0, en=1: next cycle sel=onehot(idx), cur_idx=idx, stay IDLE; one-cycle latency.
REQ-018 IDLE, sweep_start=0, en=0: next cycle sel=0, cur_idx=0.
REQ-019 sweep_start and en both high in IDLE: sweep_start wins; en ignored.
REQ-020 SWEEP, hold=1: state, cur_idx, latched last unchanged; sel=0, sel_valid=0 while held.
REQ-021 SWEEP, hold=0, cur_idx!=last: cur_idx increments mod OUT_W (OUT_W-1 wraps to 0); sel=onehot(new cur_idx).
REQ-022 SWEEP, hold=0, cur_idx==last: next cycle DONE, sel=0, cur_idx=0.
REQ-023 Returning from hold SHALL resume at the held cur_idx (no index skipped or repeated).
REQ-024 Sweep SHALL assert each index exactly once: (last-first) mod OUT_W + 1 active cycles, plus hold cycles.
REQ-025 sweep_first==sweep_last SHALL give exactly one active cycle.
REQ-026 sweep_first > sweep_last SHALL wrap through OUT_W-1 and 0.
REQ-027 DONE: done=1, sel=0, busy=0 for one cycle, then IDLE; en/sweep_start in DONE ignored.
REQ-028 en, sweep_start, sweep_first, sweep_last, idx SHALL be ignored during SWEEP.
REQ-029 sel SHALL never have more than one bit set in any cycle.

Reset
REQ-030 clear=1 SHALL immediately force IDLE, sel=0, sel_valid=0, cur_idx=0, busy=0, done=0, latched last=0, independent of clock.
REQ-031 clear asserted mid-sweep SHALL abort it; no done pulse follows; first edge after release behaves as IDLE.

Verification
REQ-032 Direct: IDX_W=4, en=1 idx=9 at edge t -> sel=16'h0200, cur_idx=9, sel_valid=1 after t; en=0 at t+1 -> sel=0 after t+1.
REQ-033 Plain sweep: sweep_start, first=2, last=5 -> sel 0x0004,0x0008,0x0010,0x0020 on 4 consecutive cycles, busy high throughout, then done=1 one cycle, then IDLE.
REQ-034 Wrap sweep: first=14, last=1 -> cur_idx 14,15,0,1 then done; single-index sweep first=last=7 -> one cycle sel=0x0080 then done.
REQ-035 Hold: sweep first=0,last=3, hold=1 for 2 cycles while cur_idx=1 -> sel=0 those cycles, then cur_idx 1,2,3; total busy = 6 cycles.
REQ-036 Priority/ignore: sweep_start=1 and en=1 idx=12 together -> sweep runs, sel never 0x1000 unless in sweep range; en pulses during SWEEP have no effect.
REQ-037 Reset: clear pulsed between edges while cur_idx=2 of sweep 0..5 -> outputs 0 before next edge; no done pulse; subsequent en idx=3 -> sel=0x0008.
